// File: rtl/seq_div.sv
// Restoring signed/unsigned 32-bit divider producing MIPS-style HI (remainder) / LO (quotient).
// Latency: fixed 33 cycles from the accepting edge to done, independent of operands.
// Backpressure: start is ignored while busy; busy stalls the requester until done pulses.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign_flag,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;        // partial remainder, always < divisor magnitude
    logic [WIDTH-1:0] quo;        // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] a_raw;      // original dividend, returned as HI on divide by zero
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_shift;  // one extra bit so the shifted remainder never overflows
    logic [WIDTH:0]   trial;
    logic             last_iter;

    // Operand magnitudes and the trial subtraction for the current iteration
    always_comb begin
        a_neg     = sign_flag & A[WIDTH-1];
        b_neg     = sign_flag & B[WIDTH-1];
        a_abs     = a_neg ? -A : A;
        b_abs     = b_neg ? -B : B;
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, b_mag};
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and busy indication
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one quotient bit per CALC edge, sign fix-up on FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            b_mag <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_raw <= A;
                        quo   <= a_abs;
                        b_mag <= b_abs;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        div0  <= (B == '0);
                        rem   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    // Divide by zero returns raw all-ones / dividend with no sign fix-up
                    if (div0) begin
                        LO <= '1;
                        HI <= a_raw;
                    end else begin
                        LO <= neg_q ? -quo : quo;
                        HI <= neg_r ? -rem : rem;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle 32-bit integer divider for the CPU's DIV/DIVU path, complementing the combinational multiplier on the HI/LO datapath. It accepts a dividend and divisor on a start pulse. It computes the quotient and remainder iteratively, one bit per cycle, using magnitude restoring division. Results are delivered in MIPS HI/LO form: quotient to LO, remainder to HI. The controller stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand and result width; the iteration count equals `WIDTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a division; sampled only when idle.
- `sign_flag` input 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `A` input WIDTH: dividend; sampled with `start`.
- `B` input WIDTH: divisor; sampled with `start`.
- `HI` output WIDTH: remainder of the last completed division.
- `LO` output WIDTH: quotient of the last completed division.
- `busy` output 1: high from the accepting edge until the completing edge.
- `done` output 1: one-cycle pulse; `HI`/`LO` are valid from this cycle onward.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - `start`=1 at an edge: latch `sign_flag`; latch |A| and |B|, taking two's-complement magnitudes only when signed and the MSB is set.
  - Record neg_q = A[31]^B[31] and neg_r = A[31]. Both are forced to 0 when unsigned.
  - Record div0 = (B==0).
  - Clear the partial remainder (WIDTH+1 bits) and the 5-bit counter; go to CALC with `busy`=1.
- **CALC**
  - Each edge: shift {rem, quo} left by 1, bringing in the next dividend bit.
  - Trial subtract the divisor magnitude. If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Counter increments; after iteration WIDTH (counter == WIDTH-1) go to FIX.
- **FIX**
  - One edge applies signs: LO = neg_q ? −quo : quo; HI = neg_r ? −rem : rem.
  - On that edge: `busy`←0, `done`←1, next state IDLE.
- **Divide by zero** (div0=1): the full latency still applies. The result is LO = all ones and HI = A as originally presented, raw in both modes; the sign fix is suppressed.
- **Overflow** (signed 0x80000000 / −1): LO = 0x80000000, HI = 0. This falls out of the magnitude path and needs no special case.
- `start` while `busy`=1 is ignored entirely; operand changes during CALC/FIX have no effect.
- `HI`/`LO` change only on the FIX edge and hold until the next completion.
- `done` is high for exactly one cycle per accepted start.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0): `HI`=0, `LO`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Latency: `start` accepted at edge E0 → `busy`=1 after E0. Iterations occur at E1..E32, FIX at E33. `done`=1 and `busy`=0 after E33, i.e. 33 cycles, independent of operand values.
- Back-to-back: `start` high during the `done` cycle (state IDLE) is accepted at the next edge. Sustained throughput is one division per 34 cycles.
- Reset mid-operation aborts with no `done` pulse and restores all reset values, including `HI`/`LO`.
- `done` and `busy` are never both 1.

## Test plan
- After reset, check `HI`=`LO`=0 and `busy`=`done`=0. Then run unsigned A=100, B=7: `done` exactly 33 cycles after accept, LO=14, HI=2, `busy` high for 33 cycles.
- Signed A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- Signed A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. The same operands unsigned → LO=0, HI=0x80000000.
- Divide by zero with A=0x12345678, B=0 in both modes → LO=0xFFFFFFFF, HI=0x12345678 after 33 cycles.
- Start unsigned A=50, B=5, then pulse `start` with A=9, B=3 at cycle 10 → that start is ignored and the result is LO=10, HI=0. A new start asserted in the `done` cycle is accepted and completes 33 cycles later.
- Assert `rst_n`=0 at cycle 15 of a division → outputs go to 0 immediately and no `done` occurs. Release reset and run 81/9 → LO=9, HI=0.
